// File: rtl/mem_map_pkg.sv
// Shared sizing constants for the memory-map datapath and its sequencing controller.
package mem_map_pkg;
  localparam int DW      = 8;
  localparam int AW_A    = 3;
  localparam int AW_B    = 2;
  localparam int DEPTH_A = 1 << AW_A;
  localparam int DEPTH_B = 1 << AW_B;
  localparam int CNT_W   = 3;
  localparam logic [CNT_W-1:0] FULL_CNT = 3'd4;
endpackage

// File: rtl/mem_map_datapath_mem_bank.sv
// Generic single-port-write, registered-read RAM bank; contents survive reset, only the read register clears.
module mem_bank #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;

  always_comb begin
    rdata_d = mem_q[raddr];
  end

  // Non-blocking update gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[waddr] <= wdata;
    end
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_map_datapath.sv
// Two-bank datapath: A feeds a pairwise-sum pipeline whose results are stored in B,
// with a saturating write counter and sticky overflow flag on B.
module mem_map_datapath #(
  parameter int DW   = mem_map_pkg::DW,
  parameter int AW_A = mem_map_pkg::AW_A,
  parameter int AW_B = mem_map_pkg::AW_B
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            WEA,
  input  logic            IncA,
  input  logic            WEB,
  input  logic            IncB,
  input  logic [DW-1:0]   DataInA,
  input  logic [AW_B-1:0] RdAddrB,
  output logic [AW_A-1:0] AddrA,
  output logic [AW_B-1:0] AddrB,
  output logic [DW:0]     DOutB,
  output logic            FullB,
  output logic            ErrOvf
);
  import mem_map_pkg::*;

  logic [AW_A-1:0]  addr_a_d, addr_a_q;
  logic [AW_B-1:0]  addr_b_d, addr_b_q;
  logic [DW-1:0]    read_a;
  logic [DW-1:0]    prev_a_d, prev_a_q;
  logic [DW:0]      sum_ab;
  logic [DW:0]      dout_b;
  logic [CNT_W-1:0] count_b_d, count_b_q;
  logic             err_ovf_d, err_ovf_q;
  logic             full_b;

  assign full_b = (count_b_q == FULL_CNT);
  assign sum_ab = {1'b0, read_a} + {1'b0, prev_a_q};

  always_comb begin
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    prev_a_d  = read_a;
    count_b_d = count_b_q;
    err_ovf_d = err_ovf_q;
    if (IncA) begin
      addr_a_d = addr_a_q + 1'b1;
    end
    if (IncB) begin
      addr_b_d = addr_b_q + 1'b1;
    end
    // Writes past the fourth still land in B, but are flagged as an overflow.
    if (WEB) begin
      if (full_b) begin
        err_ovf_d = 1'b1;
      end else begin
        count_b_d = count_b_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      prev_a_q  <= '0;
      count_b_q <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      prev_a_q  <= prev_a_d;
      count_b_q <= count_b_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  mem_bank #(.W(DW), .AW(AW_A)) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (WEA),
    .waddr (addr_a_q),
    .wdata (DataInA),
    .raddr (addr_a_q),
    .rdata (read_a)
  );

  mem_bank #(.W(DW + 1), .AW(AW_B)) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (WEB),
    .waddr (addr_b_q),
    .wdata (sum_ab),
    .raddr (RdAddrB),
    .rdata (dout_b)
  );

  assign AddrA  = addr_a_q;
  assign AddrB  = addr_b_q;
  assign DOutB  = dout_b;
  assign FullB  = full_b;
  assign ErrOvf = err_ovf_q;
endmodule

// File: tb/tb_mem_map_datapath.sv
// Self-checking bench for mem_map_datapath: directed scenarios plus a randomized run against an array-based model.
module tb_mem_map_datapath;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       WEA = 1'b0, IncA = 1'b0, WEB = 1'b0, IncB = 1'b0;
  logic [7:0] DataInA = '0;
  logic [1:0] RdAddrB = '0;
  logic [2:0] AddrA;
  logic [1:0] AddrB;
  logic [8:0] DOutB;
  logic       FullB, ErrOvf;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: the two memories as arrays, addresses as integers, plus validity of each word.
  logic [7:0] m_mem_a [8];
  bit         m_va    [8];
  logic [8:0] m_mem_b [4];
  bit         m_vb    [4];
  int         m_addr_a, m_addr_b, m_count;
  bit         m_err;
  logic [7:0] m_read, m_prev;
  bit         m_read_v, m_prev_v;
  logic [8:0] m_dout;
  bit         m_dout_v;

  mem_map_datapath dut (
    .clk     (clk),
    .reset   (reset),
    .WEA     (WEA),
    .IncA    (IncA),
    .WEB     (WEB),
    .IncB    (IncB),
    .DataInA (DataInA),
    .RdAddrB (RdAddrB),
    .AddrA   (AddrA),
    .AddrB   (AddrB),
    .DOutB   (DOutB),
    .FullB   (FullB),
    .ErrOvf  (ErrOvf)
  );

  always #5 clk = ~clk;

  task automatic step(input bit rst, input bit wea, input bit inca, input bit web, input bit incb,
                      input logic [7:0] din, input logic [1:0] rdb);
    int         sum;
    bit         sum_v;
    logic [7:0] nr;
    bit         nr_v;
    reset = rst; WEA = wea; IncA = inca; WEB = web; IncB = incb; DataInA = din; RdAddrB = rdb;
    @(posedge clk);
    if (rst) begin
      m_addr_a = 0; m_addr_b = 0; m_count = 0; m_err = 0;
      m_read = '0; m_read_v = 1; m_prev = '0; m_prev_v = 1; m_dout = '0; m_dout_v = 1;
    end else begin
      sum   = int'(m_read) + int'(m_prev);
      sum_v = m_read_v && m_prev_v;
      nr    = m_mem_a[m_addr_a];
      nr_v  = m_va[m_addr_a];
      m_prev = m_read; m_prev_v = m_read_v;
      m_read = nr;     m_read_v = nr_v;
      m_dout = m_mem_b[rdb]; m_dout_v = m_vb[rdb];
      if (wea) begin
        m_mem_a[m_addr_a] = din;
        m_va[m_addr_a] = 1;
      end
      if (web) begin
        m_mem_b[m_addr_b] = 9'(sum);
        m_vb[m_addr_b] = sum_v;
        if (m_count == 4) m_err = 1;
        else m_count++;
      end
      if (inca) m_addr_a = (m_addr_a + 1) % 8;
      if (incb) m_addr_b = (m_addr_b + 1) % 4;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom));
    end
    n_checks++; if (AddrA !== 3'd0) begin n_errors++; $display("[TB] FAIL reset_addr_a: got %0d want 0", AddrA); end
    n_checks++; if (AddrB !== 2'd0) begin n_errors++; $display("[TB] FAIL reset_addr_b: got %0d want 0", AddrB); end
    n_checks++; if (DOutB !== 9'd0) begin n_errors++; $display("[TB] FAIL reset_dout_b: got %0d want 0", DOutB); end
    n_checks++; if (FullB !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_full_b: got %b want 0", FullB); end
    n_checks++; if (ErrOvf !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_err_ovf: got %b want 0", ErrOvf); end
  endtask

  task automatic test_fill_a();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, 0, 8'(10 * (i + 1)), 2'd0);
      n_checks++;
      if (AddrA !== 3'((i + 1) % 8)) begin
        n_errors++; $display("[TB] FAIL fill_addr_a[%0d]: got %0d want %0d", i, AddrA, (i + 1) % 8);
      end
    end
  endtask

  task automatic test_sum_pairs();
    step(0, 0, 0, 0, 0, 8'd0, 2'd0);
    step(0, 0, 0, 0, 0, 8'd0, 2'd0);
    n_checks++; if (dut.read_a !== 8'd10) begin n_errors++; $display("[TB] FAIL hold_read_a: got %0d want 10", dut.read_a); end
    for (int p = 1; p <= 9; p++) begin
      step(0, 0, 1, (p >= 3 && p % 2 == 1), (p >= 3 && p % 2 == 1), 8'd0, 2'd0);
      if (p <= 8) begin
        n_checks++;
        if (dut.sum_ab !== ((p == 1) ? 9'd20 : 9'(20 * p - 10))) begin
          n_errors++; $display("[TB] FAIL pair_sum[%0d]: got %0d want %0d", p, dut.sum_ab, (p == 1) ? 20 : 20 * p - 10);
        end
      end
    end
    n_checks++; if (AddrB !== 2'd0) begin n_errors++; $display("[TB] FAIL pair_addr_b: got %0d want 0", AddrB); end
    n_checks++; if (FullB !== 1'b1) begin n_errors++; $display("[TB] FAIL pair_full_b: got %b want 1", FullB); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 8'd0, 2'(i));
      n_checks++;
      if (DOutB !== 9'(30 + 40 * i)) begin
        n_errors++; $display("[TB] FAIL pair_memb[%0d]: got %0d want %0d", i, DOutB, 30 + 40 * i);
      end
    end
  endtask

  task automatic test_overflow();
    n_checks++; if (ErrOvf !== 1'b0) begin n_errors++; $display("[TB] FAIL ovf_before: got %b want 0", ErrOvf); end
    step(0, 0, 0, 1, 0, 8'd0, 2'd0);
    n_checks++; if (ErrOvf !== 1'b1) begin n_errors++; $display("[TB] FAIL ovf_set: got %b want 1", ErrOvf); end
    n_checks++; if (FullB !== 1'b1) begin n_errors++; $display("[TB] FAIL ovf_full_b: got %b want 1", FullB); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 8'd0, 2'd0);
      n_checks++; if (ErrOvf !== 1'b1) begin n_errors++; $display("[TB] FAIL ovf_sticky[%0d]: got %b want 1", i, ErrOvf); end
    end
    n_checks++;
    if (DOutB !== m_mem_b[0] || DOutB === 9'd30) begin
      n_errors++; $display("[TB] FAIL ovf_overwrite: got %0d want %0d", DOutB, m_mem_b[0]);
    end
  endtask

  task automatic test_read_during_write();
    logic [7:0] old_val;
    step(0, 0, 0, 0, 0, 8'd0, 2'd0);
    old_val = m_mem_a[m_addr_a];
    step(0, 1, 0, 0, 0, 8'hA5, 2'd0);
    n_checks++; if (dut.read_a !== old_val) begin n_errors++; $display("[TB] FAIL rdw_old: got %0d want %0d", dut.read_a, old_val); end
    step(0, 0, 0, 0, 0, 8'd0, 2'd0);
    n_checks++; if (dut.read_a !== 8'hA5) begin n_errors++; $display("[TB] FAIL rdw_new: got %0d want 165", dut.read_a); end
  endtask

  task automatic test_reset_mid();
    while (m_addr_a != 5) step(0, 0, 1, 0, 0, 8'd0, 2'd0);
    while (m_addr_b != 2) step(0, 0, 0, 0, 1, 8'd0, 2'd0);
    n_checks++; if (AddrA !== 3'd5 || AddrB !== 2'd2 || ErrOvf !== 1'b1) begin
      n_errors++; $display("[TB] FAIL mid_setup: got a=%0d b=%0d e=%b want a=5 b=2 e=1", AddrA, AddrB, ErrOvf);
    end
    step(1, 1, 1, 1, 1, 8'h00, 2'd2);
    n_checks++; if (AddrA !== 3'd0 || AddrB !== 2'd0 || DOutB !== 9'd0 || FullB !== 1'b0 || ErrOvf !== 1'b0 || dut.read_a !== 8'd0) begin
      n_errors++; $display("[TB] FAIL mid_reset: got a=%0d b=%0d d=%0d f=%b e=%b r=%0d want all 0", AddrA, AddrB, DOutB, FullB, ErrOvf, dut.read_a);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 8'd0, 2'(i));
      n_checks++;
      if (DOutB !== m_mem_b[i]) begin n_errors++; $display("[TB] FAIL mid_keep[%0d]: got %0d want %0d", i, DOutB, m_mem_b[i]); end
    end
  endtask

  task automatic test_max_sum();
    step(0, 1, 1, 0, 0, 8'd255, 2'd0);
    step(0, 1, 1, 0, 0, 8'd255, 2'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 8'd0, 2'd0);
    step(0, 0, 0, 0, 0, 8'd0, 2'd0);
    step(0, 0, 0, 0, 0, 8'd0, 2'd0);
    n_checks++; if (dut.sum_ab !== 9'd510) begin n_errors++; $display("[TB] FAIL max_sum: got %0d want 510", dut.sum_ab); end
    step(0, 0, 0, 1, 0, 8'd0, 2'd0);
    n_checks++; if (DOutB !== m_dout) begin n_errors++; $display("[TB] FAIL max_old: got %0d want %0d", DOutB, m_dout); end
    step(0, 0, 0, 0, 0, 8'd0, 2'd0);
    n_checks++; if (DOutB !== 9'h1FE) begin n_errors++; $display("[TB] FAIL max_dout: got %0h want 1fe", DOutB); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
           1'($urandom), 8'($urandom), 2'($urandom));
      n_checks++; if (AddrA !== 3'(m_addr_a)) begin n_errors++; $display("[TB] FAIL rnd_addr_a@%0d: got %0d want %0d", c, AddrA, m_addr_a); end
      n_checks++; if (AddrB !== 2'(m_addr_b)) begin n_errors++; $display("[TB] FAIL rnd_addr_b@%0d: got %0d want %0d", c, AddrB, m_addr_b); end
      n_checks++; if (FullB !== (m_count == 4)) begin n_errors++; $display("[TB] FAIL rnd_full_b@%0d: got %b want %b", c, FullB, m_count == 4); end
      n_checks++; if (ErrOvf !== m_err) begin n_errors++; $display("[TB] FAIL rnd_err_ovf@%0d: got %b want %b", c, ErrOvf, m_err); end
      if (m_dout_v) begin
        n_checks++; if (DOutB !== m_dout) begin n_errors++; $display("[TB] FAIL rnd_dout_b@%0d: got %0d want %0d", c, DOutB, m_dout); end
      end
      if (m_read_v) begin
        n_checks++; if (dut.read_a !== m_read) begin n_errors++; $display("[TB] FAIL rnd_read_a@%0d: got %0d want %0d", c, dut.read_a, m_read); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_mem_a[i] = '0; m_va[i] = 0; end
    for (int i = 0; i < 4; i++) begin m_mem_b[i] = '0; m_vb[i] = 0; end
    test_reset();
    test_fill_a();
    test_sum_pairs();
    test_overflow();
    test_read_during_write();
    test_reset_mid();
    test_max_sum();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
